// File: rtl/audio_note_sched_pkg.sv
// Shared widths, state encoding and clock constants for the note scheduler.
package audio_note_sched_pkg;

  localparam int unsigned NOTE_W           = 20;
  localparam int unsigned DUR_W            = 10;
  localparam int unsigned TICKS_PER_MS_40M = 40000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/audio_note_sched_if.sv
// Requester-side bus of the note scheduler: request levels, note parameters and status.
interface audio_note_sched_if
  import audio_note_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]        req;
  logic [NREQ*NOTE_W-1:0] note_half;
  logic [NREQ*DUR_W-1:0]  note_dur;
  logic [NREQ-1:0]        ack;
  logic [NREQ-1:0]        done;
  logic                   aborted;
  logic [2:0]             grant_id;
  logic                   busy;
  logic                   spk_out;

  modport master (
    output req, note_half, note_dur,
    input  ack, done, aborted, grant_id, busy, spk_out
  );

  modport slave (
    input  req, note_half, note_dur,
    output ack, done, aborted, grant_id, busy, spk_out
  );
endinterface

// File: rtl/audio_note_sched_tone_div.sv
// Square-wave tone divider: toggles sq every `half` enabled clocks; silent when disabled or half==0.
module audio_tone_div
  import audio_note_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NOTE_W-1:0] half,
  output logic              sq
);
  logic [NOTE_W-1:0] tone_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !en || half == '0) begin
      tone_cnt <= '0;
      sq       <= 1'b0;
    end else if (tone_cnt == half - NOTE_W'(1)) begin
      tone_cnt <= '0;
      sq       <= ~sq;
    end else begin
      tone_cnt <= tone_cnt + NOTE_W'(1);
    end
  end
endmodule

// File: rtl/audio_note_sched.sv
// Round-robin note scheduler sharing one tone generator among NREQ requesters.
// Optional build macro AUDIO_PREEMPT_EN: requester 0 preempts any other note in progress.
module audio_note_sched
  import audio_note_sched_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned TICKS_PER_MS = TICKS_PER_MS_40M,
  parameter int unsigned GAP_MS       = 1
) (
  input logic               clock_40MHz,
  input logic               reset_n,
  audio_note_sched_if.slave bus
);
  localparam int unsigned      MS_W     = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(TICKS_PER_MS - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_t            state;
  logic [2:0]        rr_ptr;
  logic [NOTE_W-1:0] half_r;
  logic [DUR_W-1:0]  dur_cnt;
  logic [MS_W-1:0]   ms_cnt;
  logic              zero_pend;
  logic [NREQ-1:0]   ack_r;
  logic [NREQ-1:0]   done_r;
  logic              aborted_r;
  logic [2:0]        grant_r;
  logic              busy_r;

  logic [NREQ-1:0]   req_rot;
  logic [2:0]        off;
  logic [3:0]        sum;
  logic              hit;
  logic [2:0]        pick;
  logic [NOTE_W-1:0] sel_half;
  logic [DUR_W-1:0]  sel_dur;
  logic              preempt;
  logic              start;
  logic [2:0]        start_id;
  logic [NOTE_W-1:0] start_half;
  logic [DUR_W-1:0]  start_dur;
  logic              ms_wrap;
  logic              seg_last;
  logic              tone_en;

`ifdef AUDIO_PREEMPT_EN
  assign preempt = (state != ST_IDLE) && bus.req[0] && (grant_r != 3'd0);
`else
  assign preempt = 1'b0;
`endif

  // Requests are rotated so bit 0 is rr_ptr; the first set bit gives the offset from rr_ptr.
  always_comb begin
    req_rot  = NREQ'({bus.req, bus.req} >> rr_ptr);
    hit      = 1'b0;
    off      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!hit && req_rot[k]) begin
        hit = 1'b1;
        off = 3'(k);
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
    pick     = sum[2:0];
    sel_half = '0;
    sel_dur  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (3'(k) == pick) begin
        sel_half = bus.note_half[k*NOTE_W +: NOTE_W];
        sel_dur  = bus.note_dur[k*DUR_W +: DUR_W];
      end
    end
  end

  always_comb begin
    start      = preempt || (state == ST_IDLE && !zero_pend && hit);
    start_id   = preempt ? 3'd0 : pick;
    start_half = preempt ? bus.note_half[NOTE_W-1:0] : sel_half;
    start_dur  = preempt ? bus.note_dur[DUR_W-1:0] : sel_dur;
    ms_wrap    = (ms_cnt == MS_LAST);
    seg_last   = ms_wrap && (dur_cnt == DUR_W'(1));
    // Tone is held off on the last PLAY cycle and on preemption so spk_out is 0 the cycle after.
    tone_en    = (state == ST_PLAY) && !seg_last && !preempt;
  end

  always_ff @(posedge clock_40MHz) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      half_r    <= '0;
      dur_cnt   <= '0;
      ms_cnt    <= '0;
      zero_pend <= 1'b0;
      ack_r     <= '0;
      done_r    <= '0;
      aborted_r <= 1'b0;
      grant_r   <= '0;
      busy_r    <= 1'b0;
    end else begin
      ack_r     <= '0;
      done_r    <= '0;
      aborted_r <= 1'b0;
      if (start) begin
        ack_r   <= ONE_HOT0 << start_id;
        grant_r <= start_id;
        half_r  <= start_half;
        dur_cnt <= start_dur;
        ms_cnt  <= '0;
        if (preempt) begin
          done_r    <= ONE_HOT0 << grant_r;
          aborted_r <= 1'b1;
        end else begin
          rr_ptr <= (start_id == 3'(NREQ - 1)) ? 3'd0 : start_id + 3'd1;
        end
        // A zero-length note idles one cycle and then reports done.
        if (start_dur == '0) begin
          state     <= ST_IDLE;
          busy_r    <= 1'b0;
          zero_pend <= 1'b1;
        end else begin
          state     <= ST_PLAY;
          busy_r    <= 1'b1;
          zero_pend <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (zero_pend) begin
              zero_pend <= 1'b0;
              done_r    <= ONE_HOT0 << grant_r;
            end
          end
          ST_PLAY, ST_GAP: begin
            if (seg_last) begin
              ms_cnt <= '0;
              if (state == ST_PLAY && GAP_MS != 0) begin
                state   <= ST_GAP;
                dur_cnt <= DUR_W'(GAP_MS);
              end else begin
                state  <= ST_IDLE;
                busy_r <= 1'b0;
                done_r <= ONE_HOT0 << grant_r;
              end
            end else if (ms_wrap) begin
              ms_cnt  <= '0;
              dur_cnt <= dur_cnt - DUR_W'(1);
            end else begin
              ms_cnt <= ms_cnt + MS_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  audio_tone_div u_tone (
    .clk   (clock_40MHz),
    .rst_n (reset_n),
    .en    (tone_en),
    .half  (half_r),
    .sq    (bus.spk_out)
  );

  assign bus.ack      = ack_r;
  assign bus.done     = done_r;
  assign bus.aborted  = aborted_r;
  assign bus.grant_id = grant_r;
  assign bus.busy     = busy_r;
endmodule
